// File: rtl/seq_disp_pkg.sv
// Shared types, segment constants and small helpers for the hit-count display.
package seq_disp_pkg;

    typedef enum logic [1:0] {
        BLANK,
        SHOW_TENS,
        SHOW_UNITS
    } disp_state_e;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_ALL   = 8'hFF;
    localparam logic [7:0] SEG_DP    = 8'h80;
    localparam logic [7:0] SEG_BAD   = 8'h40;

    // Returns {carry, digit}; carry is set when the digit rolls from 9 to 0.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d);
        if (d >= 4'd9) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, d + 4'd1};
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to 7-segment decoder (bit0=a .. bit6=g, active-high).
module bcd_to_seg (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    import seq_disp_pkg::*;

    always_comb begin
        seg = SEG_BAD[6:0];
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_BAD[6:0];
        endcase
    end

endmodule

// File: rtl/seq_hit_display.sv
// Counts rising edges of the detector output in BCD and shows the count on a single
// multiplexed 7-segment digit, flashing all segments briefly on every new hit.
module seq_hit_display #(
    parameter int unsigned DWELL_CYCLES = 5_000_000,
    parameter int unsigned BLANK_CYCLES = 1_250_000,
    parameter int unsigned FLASH_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       hit,
    input  logic       clr,
    output logic [7:0] seg_out,
    output logic [7:0] count_bcd,
    output logic       ovf
);
    import seq_disp_pkg::*;

    // One phase timer serves both the digit dwell and the blank gap.
    localparam int unsigned PHASE_MAX = max_u(DWELL_CYCLES, BLANK_CYCLES);
    localparam int unsigned DW        = $clog2(PHASE_MAX);
    localparam int unsigned FW        = $clog2(FLASH_CYCLES + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [DW-1:0] BLANK_LAST = DW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);
    localparam logic [FW-1:0] FLASH_ONE  = FW'(1);

    logic          hit_q;
    logic [3:0]    tens_q;
    logic [3:0]    units_q;
    logic          ovf_q;
    disp_state_e   state_q;
    logic [DW-1:0] dwell_q;
    logic [FW-1:0] flash_q;
    logic [7:0]    seg_q;

    logic          hit_rise;
    logic          flash_on;
    logic [4:0]    units_nxt;
    logic [4:0]    tens_nxt;
    disp_state_e   resume_state;
    logic [3:0]    digit_sel;
    logic [6:0]    digit_seg;
    logic [7:0]    seg_d;

    assign hit_rise  = hit & ~hit_q;
    assign flash_on  = (flash_q != '0);
    assign units_nxt = bcd_digit_inc(units_q);
    assign tens_nxt  = units_nxt[4] ? bcd_digit_inc(tens_q) : {1'b0, tens_q};

    // Leading-zero suppression: skip the tens digit while it is zero.
    assign resume_state = (tens_q != 4'd0) ? SHOW_TENS : SHOW_UNITS;

    assign digit_sel = (state_q == SHOW_TENS) ? tens_q : units_q;

    bcd_to_seg u_bcd_to_seg (
        .bcd (digit_sel),
        .seg (digit_seg)
    );

    always_comb begin
        seg_d = SEG_BLANK;
        if (flash_on) begin
            seg_d = SEG_ALL;
        end else begin
            case (state_q)
                SHOW_TENS:  seg_d = {1'b0, digit_seg} | SEG_DP;
                SHOW_UNITS: seg_d = {1'b0, digit_seg};
                default:    seg_d = SEG_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q   <= 1'b0;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            ovf_q   <= 1'b0;
            state_q <= BLANK;
            dwell_q <= '0;
            flash_q <= '0;
            seg_q   <= SEG_BLANK;
        end else if (ena) begin
            hit_q <= hit;
            seg_q <= seg_d;
            if (clr) begin
                tens_q  <= 4'd0;
                units_q <= 4'd0;
                ovf_q   <= 1'b0;
                flash_q <= '0;
                state_q <= SHOW_UNITS;
                dwell_q <= '0;
            end else if (hit_rise) begin
                units_q <= units_nxt[3:0];
                tens_q  <= tens_nxt[3:0];
                if (tens_nxt[4]) begin
                    ovf_q <= 1'b1;
                end
                flash_q <= FLASH_LOAD;
            end else if (flash_on) begin
                flash_q <= flash_q - FLASH_ONE;
                // Last flash cycle: restart the digit sequence with a fresh dwell.
                if (flash_q == FLASH_ONE) begin
                    state_q <= resume_state;
                    dwell_q <= '0;
                end
            end else begin
                case (state_q)
                    SHOW_TENS: begin
                        if (dwell_q == DWELL_LAST) begin
                            state_q <= SHOW_UNITS;
                            dwell_q <= '0;
                        end else begin
                            dwell_q <= dwell_q + DWELL_ONE;
                        end
                    end
                    SHOW_UNITS: begin
                        if (dwell_q == DWELL_LAST) begin
                            state_q <= BLANK;
                            dwell_q <= '0;
                        end else begin
                            dwell_q <= dwell_q + DWELL_ONE;
                        end
                    end
                    BLANK: begin
                        if (dwell_q == BLANK_LAST) begin
                            state_q <= resume_state;
                            dwell_q <= '0;
                        end else begin
                            dwell_q <= dwell_q + DWELL_ONE;
                        end
                    end
                    default: begin
                        state_q <= BLANK;
                        dwell_q <= '0;
                    end
                endcase
            end
        end
    end

    assign seg_out   = seg_q;
    assign count_bcd = {tens_q, units_q};
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_hit_display.sv
// Scoreboard bench for seq_hit_display: a per-edge reference model queues expected outputs,
// a monitor pops and compares them one step after each rising edge.
module tb_seq_hit_display;

    localparam int unsigned DWELL  = 4;
    localparam int unsigned BLANKC = 2;
    localparam int unsigned FLASH  = 3;

    localparam int M_BLANK = 0;
    localparam int M_TENS  = 1;
    localparam int M_UNITS = 2;

    localparam logic [7:0] DIGIT_SEG [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       hit;
    logic       clr;
    logic [7:0] seg_out;
    logic [7:0] count_bcd;
    logic       ovf;

    seq_hit_display #(
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANKC),
        .FLASH_CYCLES (FLASH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .hit       (hit),
        .clr       (clr),
        .seg_out   (seg_out),
        .count_bcd (count_bcd),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] cnt;
        logic       ovf;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: count as a plain integer, display as a mode with cycles remaining.
    int         m_count;
    bit         m_ovf;
    bit         m_hit_prev;
    int         m_mode;
    int         m_left;
    int         m_flash;
    logic [7:0] m_seg;

    function automatic logic [7:0] to_bcd(input int c);
        logic [7:0] b;
        b[7:4] = 4'(c / 10);
        b[3:0] = 4'(c % 10);
        return b;
    endfunction

    function automatic logic [7:0] render(input int mode, input int count, input int flash);
        if (flash > 0) return 8'hFF;
        if (mode == M_TENS) return DIGIT_SEG[count / 10] | 8'h80;
        if (mode == M_UNITS) return DIGIT_SEG[count % 10];
        return 8'h00;
    endfunction

    task automatic m_reset();
        m_count    = 0;
        m_ovf      = 1'b0;
        m_hit_prev = 1'b0;
        m_mode     = M_BLANK;
        m_left     = BLANKC;
        m_flash    = 0;
        m_seg      = 8'h00;
    endtask

    task automatic m_resume();
        m_mode = (m_count >= 10) ? M_TENS : M_UNITS;
        m_left = DWELL;
    endtask

    task automatic m_step();
        bit rise;
        m_seg      = render(m_mode, m_count, m_flash);
        rise       = hit && !m_hit_prev;
        m_hit_prev = hit;
        if (clr) begin
            m_count = 0;
            m_ovf   = 1'b0;
            m_flash = 0;
            m_mode  = M_UNITS;
            m_left  = DWELL;
        end else if (rise) begin
            m_count = (m_count + 1) % 100;
            if (m_count == 0) m_ovf = 1'b1;
            m_flash = FLASH;
        end else if (m_flash > 0) begin
            m_flash--;
            if (m_flash == 0) m_resume();
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_mode == M_TENS) begin
                    m_mode = M_UNITS;
                    m_left = DWELL;
                end else if (m_mode == M_UNITS) begin
                    m_mode = M_BLANK;
                    m_left = BLANKC;
                end else begin
                    m_resume();
                end
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) m_reset();
            else if (ena) m_step();
            exp_q.push_back(obs_t'{m_seg, to_bcd(m_count), m_ovf});
        end
    end

    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty t=%0t: no expected entry for observed seg_out=%h",
                         $time, seg_out);
            end else begin
                e = exp_q.pop_front();
                if ({seg_out, count_bcd, ovf} !== e) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t: got seg_out=%h count_bcd=%h ovf=%b, want seg_out=%h count_bcd=%h ovf=%b",
                             $time, seg_out, count_bcd, ovf, e.seg, e.cnt, e.ovf);
                end
            end
        end
    end

    // Inputs change 2 time units after each rising edge, well clear of sampling.
    task automatic drive(input logic h, input logic c, input logic e);
        @(posedge clk);
        #2;
        hit = h;
        clr = c;
        ena = e;
    endtask

    initial begin
        logic h;
        rst_n = 1'b0;
        hit   = 1'b0;
        clr   = 1'b0;
        ena   = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Idle: blank/units pattern with the tens digit suppressed.
        repeat (24) drive(1'b0, 1'b0, 1'b1);

        // A single long pulse counts once.
        repeat (5) drive(1'b1, 1'b0, 1'b1);
        repeat (12) drive(1'b0, 1'b0, 1'b1);

        // Up to 12, then watch the tens/units/blank sequence.
        repeat (11) begin
            drive(1'b1, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b1);
        end
        repeat (30) drive(1'b0, 1'b0, 1'b1);

        // Up to 100: wrap to 00 with overflow.
        repeat (88) begin
            drive(1'b1, 1'b0, 1'b1);
            drive(1'b0, 1'b0, 1'b1);
        end
        repeat (8) drive(1'b0, 1'b0, 1'b1);

        // Clear coincident with a hit edge; hit then stays high.
        drive(1'b1, 1'b1, 1'b1);
        repeat (2) drive(1'b1, 1'b0, 1'b1);

        // Freeze mid-units with hit toggling, end high, then resume.
        for (int i = 0; i < 10; i++) drive(logic'(i % 2), 1'b0, 1'b0);
        repeat (6) drive(1'b1, 1'b0, 1'b1);
        repeat (10) drive(1'b0, 1'b0, 1'b1);

        // Randomised traffic.
        h = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) h = ~h;
            drive(h, logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 9) != 0));
        end

        // Asynchronous reset in the middle of a flash.
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        repeat (2) drive(1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (seg_out !== 8'h00 || count_bcd !== 8'h00 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got seg_out=%h count_bcd=%h ovf=%b, want 00 00 0",
                     seg_out, count_bcd, ovf);
        end
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (20) drive(1'b0, 1'b0, 1'b1);

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
